// File: rtl/mem_port_arbiter_if.sv
// Core-side (I and D) request/response signals plus the shared memory port.
// The arbiter connects through master; the core/memory environment through slave.
interface mem_port_arbiter_if #(
    parameter int DataWidth = 32,
    parameter int Address   = 8
);
    logic                 i_request;
    logic                 i_we_re;
    logic [3:0]           i_mask;
    logic [Address-1:0]   i_address;
    logic [DataWidth-1:0] i_data_in;
    logic                 i_valid;
    logic                 i_error;
    logic [DataWidth-1:0] i_data_out;

    logic                 d_request;
    logic                 d_we_re;
    logic [3:0]           d_mask;
    logic [Address-1:0]   d_address;
    logic [DataWidth-1:0] d_data_in;
    logic                 d_valid;
    logic                 d_error;
    logic [DataWidth-1:0] d_data_out;

    logic                 mem_request;
    logic                 mem_we_re;
    logic [3:0]           mem_mask;
    logic [Address-1:0]   mem_address;
    logic [DataWidth-1:0] mem_data_in;
    logic                 mem_valid;
    logic [DataWidth-1:0] mem_data_out;

    modport master (
        input  i_request, i_we_re, i_mask, i_address, i_data_in,
        output i_valid, i_error, i_data_out,
        input  d_request, d_we_re, d_mask, d_address, d_data_in,
        output d_valid, d_error, d_data_out,
        output mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
        input  mem_valid, mem_data_out
    );

    modport slave (
        output i_request, i_we_re, i_mask, i_address, i_data_in,
        input  i_valid, i_error, i_data_out,
        output d_request, d_we_re, d_mask, d_address, d_data_in,
        input  d_valid, d_error, d_data_out,
        input  mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
        output mem_valid, mem_data_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I and D requesters; request-to-valid latency is 3 cycles minimum.
// No backpressure: a repeat request while pending is dropped; ARB_RR_EN selects round-robin over fixed D>I.
module mem_port_arbiter #(
    parameter int DataWidth = 32,
    parameter int Address   = 8,
    parameter int Timeout   = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic                 we_re;
        logic [3:0]           mask;
        logic [Address-1:0]   address;
        logic [DataWidth-1:0] data_in;
    } hold_t;

    localparam logic [7:0] TimeoutCnt = 8'(Timeout);

    state_t               state, state_n;
    logic                 grant, grant_n;      // 1 = D side owns the memory port
    logic                 pending_i, pending_d;
    hold_t                hold_i, hold_d, hold_sel;
    logic [7:0]           cnt;
    logic                 timed_out;
    logic                 winner_d;
    logic                 resp_i, resp_d;
    logic                 cap_i, cap_d;
    logic [DataWidth-1:0] rd_data;

`ifdef ARB_RR_EN
    logic rr_last_d;
    // Pointer moves only on contested arbitration, so an uncontested grant does not steal the next turn.
    assign winner_d = pending_d && (!pending_i || !rr_last_d);
`else
    assign winner_d = pending_d;
`endif

    assign resp_i   = (state == RESP) && !grant;
    assign resp_d   = (state == RESP) && grant;
    assign cap_i    = bus.i_request && (!pending_i || resp_i);
    assign cap_d    = bus.d_request && (!pending_d || resp_d);
    assign hold_sel = grant_n ? hold_d : hold_i;
    assign rd_data  = (timed_out || bus.mem_we_re) ? '0 : bus.mem_data_out;

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (pending_i || pending_d) begin
                    state_n = ISSUE;
                    grant_n = winner_d;
                end
            end
            ISSUE, WAIT: begin
                if (bus.mem_valid) begin
                    state_n = RESP;
                end else if (cnt == TimeoutCnt) begin
                    state_n   = RESP;
                    timed_out = 1'b1;
                end else begin
                    state_n = WAIT;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            grant           <= 1'b0;
            busy            <= 1'b0;
            pending_i       <= 1'b0;
            pending_d       <= 1'b0;
            hold_i          <= '0;
            hold_d          <= '0;
            cnt             <= '0;
            bus.mem_request <= 1'b0;
            bus.mem_we_re   <= 1'b0;
            bus.mem_mask    <= '0;
            bus.mem_address <= '0;
            bus.mem_data_in <= '0;
            bus.i_valid     <= 1'b0;
            bus.i_error     <= 1'b0;
            bus.i_data_out  <= '0;
            bus.d_valid     <= 1'b0;
            bus.d_error     <= 1'b0;
            bus.d_data_out  <= '0;
`ifdef ARB_RR_EN
            rr_last_d       <= 1'b0;
`endif
        end else begin
            state <= state_n;
            grant <= grant_n;
            busy  <= (state_n != IDLE);

            if (cap_i) begin
                pending_i <= 1'b1;
                hold_i    <= {bus.i_we_re, bus.i_mask, bus.i_address, bus.i_data_in};
            end else if (resp_i) begin
                pending_i <= 1'b0;
            end

            if (cap_d) begin
                pending_d <= 1'b1;
                hold_d    <= {bus.d_we_re, bus.d_mask, bus.d_address, bus.d_data_in};
            end else if (resp_d) begin
                pending_d <= 1'b0;
            end

            if (state_n == ISSUE) begin
                cnt <= 8'd1;
            end else if (state_n == WAIT) begin
                cnt <= cnt + 8'd1;
            end

            // Memory fields are loaded once on entry to ISSUE and held until the next grant.
            bus.mem_request <= (state_n == ISSUE);
            if (state_n == ISSUE) begin
                bus.mem_we_re   <= hold_sel.we_re;
                bus.mem_mask    <= hold_sel.mask;
                bus.mem_address <= hold_sel.address;
                bus.mem_data_in <= hold_sel.data_in;
            end

            bus.i_valid    <= (state_n == RESP) && !grant;
            bus.i_error    <= (state_n == RESP) && !grant && timed_out;
            bus.i_data_out <= ((state_n == RESP) && !grant) ? rd_data : '0;
            bus.d_valid    <= (state_n == RESP) && grant;
            bus.d_error    <= (state_n == RESP) && grant && timed_out;
            bus.d_data_out <= ((state_n == RESP) && grant) ? rd_data : '0;

`ifdef ARB_RR_EN
            if (state == IDLE && pending_i && pending_d) begin
                rr_last_d <= grant_n;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// requests and responses into queues, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   mem_lat = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [3:0]  mask;
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } mreq_t;

    rsp_t  i_q[$];
    rsp_t  d_q[$];
    mreq_t m_q[$];

    mem_port_arbiter_if #(.DataWidth(32), .Address(8)) bus ();

    mem_port_arbiter #(.DataWidth(32), .Address(8), .Timeout(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_i(input logic [31:0] data, input logic err, input int c);
        rsp_t e;
        e.data = data; e.err = err; e.cyc = c;
        i_q.push_back(e);
    endtask

    task automatic exp_d(input logic [31:0] data, input logic err, input int c);
        rsp_t e;
        e.data = data; e.err = err; e.cyc = c;
        d_q.push_back(e);
    endtask

    task automatic exp_m(input logic we, input logic [3:0] mk, input logic [7:0] a,
                         input logic [31:0] dt, input int c);
        mreq_t m;
        m.we = we; m.mask = mk; m.addr = a; m.data = dt; m.cyc = c;
        m_q.push_back(m);
    endtask

    task automatic drive_i(input logic req, input logic we, input logic [3:0] mk,
                           input logic [7:0] a, input logic [31:0] dt);
        bus.i_request = req; bus.i_we_re = we; bus.i_mask = mk;
        bus.i_address = a;   bus.i_data_in = dt;
    endtask

    task automatic drive_d(input logic req, input logic we, input logic [3:0] mk,
                           input logic [7:0] a, input logic [31:0] dt);
        bus.d_request = req; bus.d_we_re = we; bus.d_mask = mk;
        bus.d_address = a;   bus.d_data_in = dt;
    endtask

    task automatic drain(input int max_cyc);
        int k = 0;
        int left;
        while (k < max_cyc && (i_q.size() + d_q.size() + m_q.size()) != 0) begin
            tick();
            k++;
        end
        left = i_q.size() + d_q.size() + m_q.size();
        total++;
        if (left != 0) begin
            bad++;
            $display("FAIL drain: %0d expected events outstanding, required 0", left);
            i_q.delete(); d_q.delete(); m_q.delete();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_i_valid"},  64'(bus.i_valid),     64'd0);
        chk({tag, "_i_error"},  64'(bus.i_error),     64'd0);
        chk({tag, "_i_data"},   64'(bus.i_data_out),  64'd0);
        chk({tag, "_d_valid"},  64'(bus.d_valid),     64'd0);
        chk({tag, "_d_error"},  64'(bus.d_error),     64'd0);
        chk({tag, "_d_data"},   64'(bus.d_data_out),  64'd0);
        chk({tag, "_mem_req"},  64'(bus.mem_request), 64'd0);
        chk({tag, "_mem_we"},   64'(bus.mem_we_re),   64'd0);
        chk({tag, "_mem_mask"}, 64'(bus.mem_mask),    64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_address), 64'd0);
        chk({tag, "_mem_data"}, 64'(bus.mem_data_in), 64'd0);
        chk({tag, "_busy"},     64'(busy),            64'd0);
    endtask

    function automatic logic [31:0] mem_rsp(input logic [7:0] a);
        if (a == 8'h04) return 32'hDEADBEEF;
        return {24'hC0DE00, a};
    endfunction

    // Memory model: answers each request mem_lat cycles after the ISSUE cycle.
    initial begin : memory
        bus.mem_valid    = 1'b0;
        bus.mem_data_out = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_request === 1'b1) begin
                repeat (mem_lat) @(negedge clk);
                bus.mem_valid    = 1'b1;
                bus.mem_data_out = mem_rsp(bus.mem_address);
                @(negedge clk);
                bus.mem_valid    = 1'b0;
                bus.mem_data_out = '0;
            end
        end
    end

    initial begin : monitor
        rsp_t  e;
        mreq_t m;
        forever begin
            @(negedge clk);
            if (bus.i_valid === 1'b1) begin
                if (i_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL i_valid_unexpected: got i_valid=1 data=%0h at cycle %0d, required no valid",
                             bus.i_data_out, cyc);
                end else begin
                    e = i_q.pop_front();
                    chk("i_data_out", 64'(bus.i_data_out), 64'(e.data));
                    chk("i_error",    64'(bus.i_error),    64'(e.err));
                    chk("i_cycle",    64'(cyc),            64'(e.cyc));
                end
            end
            if (bus.d_valid === 1'b1) begin
                if (d_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d_valid_unexpected: got d_valid=1 data=%0h at cycle %0d, required no valid",
                             bus.d_data_out, cyc);
                end else begin
                    e = d_q.pop_front();
                    chk("d_data_out", 64'(bus.d_data_out), 64'(e.data));
                    chk("d_error",    64'(bus.d_error),    64'(e.err));
                    chk("d_cycle",    64'(cyc),            64'(e.cyc));
                end
            end
            if (bus.mem_request === 1'b1) begin
                if (m_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mem_request_unexpected: got addr=%0h at cycle %0d, required no request",
                             bus.mem_address, cyc);
                end else begin
                    m = m_q.pop_front();
                    chk("mem_we_re",   64'(bus.mem_we_re),   64'(m.we));
                    chk("mem_mask",    64'(bus.mem_mask),    64'(m.mask));
                    chk("mem_address", 64'(bus.mem_address), 64'(m.addr));
                    chk("mem_data_in", 64'(bus.mem_data_in), 64'(m.data));
                    chk("mem_cycle",   64'(cyc),             64'(m.cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        drive_i(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive_d(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_idle("reset");
        tick();
        rst = 1'b0;
        tick();

        // I read, memory answers in the ISSUE cycle
        mem_lat = 0;
        tick(); n = cyc;
        exp_m(1'b0, 4'hF, 8'h04, 32'h0, n + 2);
        exp_i(32'hDEADBEEF, 1'b0, n + 3);
        drive_i(1'b1, 1'b0, 4'hF, 8'h04, 32'h0);
        tick(); drive_i(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drain(40);

        // D masked write returns zero data
        tick(); n = cyc;
        exp_m(1'b1, 4'b0011, 8'h10, 32'h12345678, n + 2);
        exp_d(32'h0, 1'b0, n + 3);
        drive_d(1'b1, 1'b1, 4'b0011, 8'h10, 32'h12345678);
        tick(); drive_d(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drain(40);

        // Simultaneous pair, memory latency 2: D first
        mem_lat = 2;
        tick(); n = cyc;
        exp_m(1'b0, 4'hF, 8'h20, 32'h0, n + 2);
        exp_m(1'b0, 4'hF, 8'h30, 32'h0, n + 7);
        exp_d(32'hC0DE0020, 1'b0, n + 5);
        exp_i(32'hC0DE0030, 1'b0, n + 10);
        drive_d(1'b1, 1'b0, 4'hF, 8'h20, 32'h0);
        drive_i(1'b1, 1'b0, 4'hF, 8'h30, 32'h0);
        tick();
        drive_d(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive_i(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drain(60);

        // Second simultaneous pair: order depends on arbitration mode
        tick(); n = cyc;
`ifdef ARB_RR_EN
        exp_m(1'b0, 4'hF, 8'h31, 32'h0, n + 2);
        exp_m(1'b0, 4'hF, 8'h21, 32'h0, n + 7);
        exp_i(32'hC0DE0031, 1'b0, n + 5);
        exp_d(32'hC0DE0021, 1'b0, n + 10);
`else
        exp_m(1'b0, 4'hF, 8'h21, 32'h0, n + 2);
        exp_m(1'b0, 4'hF, 8'h31, 32'h0, n + 7);
        exp_d(32'hC0DE0021, 1'b0, n + 5);
        exp_i(32'hC0DE0031, 1'b0, n + 10);
`endif
        drive_d(1'b1, 1'b0, 4'hF, 8'h21, 32'h0);
        drive_i(1'b1, 1'b0, 4'hF, 8'h31, 32'h0);
        tick();
        drive_d(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive_i(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drain(60);

        // Timeout: answer arrives 20 cycles after ISSUE, past the 16-cycle limit
        mem_lat = 20;
        tick(); n = cyc;
        exp_m(1'b0, 4'hF, 8'h40, 32'h0, n + 2);
        exp_d(32'h0, 1'b1, n + 18);
        drive_d(1'b1, 1'b0, 4'hF, 8'h40, 32'h0);
        tick(); drive_d(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        repeat (8) tick();
        @(negedge clk);
        chk("busy_in_wait", 64'(busy), 64'd1);
        drain(40);
        repeat (12) tick();

        // Duplicate while pending is dropped; request in the valid cycle is taken
        mem_lat = 0;
        tick(); n = cyc;
        exp_m(1'b0, 4'hF, 8'h50, 32'h0, n + 2);
        exp_m(1'b0, 4'hF, 8'h52, 32'h0, n + 5);
        exp_i(32'hC0DE0050, 1'b0, n + 3);
        exp_i(32'hC0DE0052, 1'b0, n + 6);
        drive_i(1'b1, 1'b0, 4'hF, 8'h50, 32'h0);
        tick(); drive_i(1'b1, 1'b0, 4'hF, 8'h51, 32'h0);
        tick(); drive_i(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        tick(); drive_i(1'b1, 1'b0, 4'hF, 8'h52, 32'h0);
        tick(); drive_i(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drain(40);

        // Reset during WAIT with both pending: everything is abandoned
        mem_lat = 5;
        tick(); n = cyc;
        exp_m(1'b0, 4'hF, 8'h60, 32'h0, n + 2);
        drive_d(1'b1, 1'b0, 4'hF, 8'h60, 32'h0);
        drive_i(1'b1, 1'b0, 4'hF, 8'h61, 32'h0);
        tick();
        drive_d(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive_i(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle("midreset");
        repeat (20) tick();
        drain(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory (request / we_re / mask / valid handshake, word address) between two requesters: instruction fetch (I) and data load/store (D) from the core.
- Each requester issues a one-cycle request pulse. The arbiter captures it into a per-requester pending buffer and serialises the buffered requests onto the memory port.
- It returns a one-cycle valid with read data, or an error on timeout.
- Sits between core and a unified memory, replacing separate instruction and data memory instances.

Parameters:
- DataWidth, 32, data bus width.
- Address, 8, word-address width.
- Timeout, 16, max cycles from issue to mem_valid before the access is aborted (range 2..255).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- i_request  input  1  instruction-side request pulse.
- i_we_re  input  1  1 = write, 0 = read.
- i_mask  input  4  byte enables.
- i_address  input  Address  word address.
- i_data_in  input  DataWidth  write data.
- i_valid  output  1  one-cycle completion strobe.
- i_error  output  1  qualifies i_valid; 1 = access timed out.
- i_data_out  output  DataWidth  read data, meaningful only when i_valid=1.
- d_request, d_we_re, d_mask, d_address, d_data_in, d_valid, d_error, d_data_out: data side, same as the i_ set.
- mem_request  output  1  request to memory.
- mem_we_re  output  1  write/read to memory.
- mem_mask  output  4  byte enables to memory.
- mem_address  output  Address  word address to memory.
- mem_data_in  output  DataWidth  write data to memory.
- mem_valid  input  1  memory completion.
- mem_data_out  input  DataWidth  memory read data.
- busy  output  1  state != IDLE.

Behaviour:
- All outputs are registered. On rst every output is 0, both pending flags and all hold registers clear, the timeout counter is 0, and the FSM is in IDLE.
- Capture:
  - x_request=1 while pending_x=0 sets pending_x at the next edge and latches we_re, mask, address and data_in into hold_x.
  - A request while pending_x=1 is dropped silently. Exception: in the RESP cycle for x, set wins over clear and the new request is captured.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any pending flag is set, select a winner, record it in grant, and go to ISSUE.
  - Default priority is fixed: D over I.
- ISSUE:
  - Exactly one cycle, with mem_request=1 and the mem_* fields driven from hold_grant.
  - mem_* fields stay stable from ISSUE through WAIT. mem_request=0 outside ISSUE.
  - The timeout counter loads 1.
- ISSUE/WAIT:
  - mem_valid=1 captures mem_data_out and goes to RESP; mem_valid is accepted in the ISSUE cycle itself.
  - Otherwise the counter increments, and the state goes to WAIT.
  - When the counter reaches Timeout with no mem_valid, go to RESP with error.
- RESP:
  - grant_valid=1 for exactly one cycle.
  - grant_data_out = captured data for reads, 0 for writes or timeout.
  - grant_error = 1 on timeout only.
  - pending_grant clears (subject to the set-wins rule). Next state is IDLE.
- Latency: request pulse in cycle c0 → pending in c1 → ISSUE in c2 → mem_valid earliest in c2 → valid in c3. A loser waits for the winner's full transaction plus one IDLE cycle.
- mem_valid in IDLE or RESP, including a late response after timeout, is ignored.
- Reset mid-transaction abandons the memory access and drops both pending requests; no valid is produced for them.
- Simultaneous I and D request pulses are both captured. Service order follows the priority rule.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration. The last granted requester gets lowest priority when both are pending; after reset D is preferred first.
- Undefined: fixed D-over-I priority, so I can starve under continuous D traffic.

Test Plan:
- I read addr 0x04, memory returns 0xDEADBEEF with mem_valid in the ISSUE cycle → i_valid=1 exactly 3 cycles after i_request, i_data_out=0xDEADBEEF, i_error=0, d_valid=0.
- D write addr 0x10, mask 4'b0011, data 0x12345678 → mem_request pulse with mem_we_re=1, mem_address=0x10, mem_mask=0011, mem_data_in=0x12345678; d_valid=1, d_data_out=0.
- I and D pulse in the same cycle, memory latency 2 → D served first, then I. With ARB_RR_EN, a second simultaneous pair is served I first.
- Memory never asserts mem_valid, Timeout=16 → d_valid=1, d_error=1, d_data_out=0, 16 cycles after ISSUE. A late mem_valid afterward produces no valid.
- Duplicate i_request while pending → single memory access, single i_valid. A new i_request in the i_valid cycle → second access issued.
- rst asserted in WAIT with both requests pending → next cycle all outputs 0, busy=0. Subsequent mem_valid is ignored; no valid on either side.
